// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main controller for the MIPS-lite CPU.
// Sequences FETCH/DECODE/EXE/MEM/WB and decodes every datapath control
// line from the current state, the IR fields and the ALU zero flag.
// Also keeps a retired-instruction counter and a sticky illegal flag.
module mc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        PCWr,
    output logic        IRWr,
    output logic        RegWr,
    output logic        MemWr,
    output logic [1:0]  EOp,
    output logic [2:0]  ALUOp,
    output logic        ALUSrcB,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  NPCOp,
    output logic [2:0]  state,
    output logic [31:0] instr_cnt,
    output logic        illegal
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXE    = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        I_ADDU, I_SUBU, I_JR, I_NOP, I_ORI, I_LW,
        I_SW, I_BEQ, I_LUI, I_J, I_JAL, I_ILLEGAL
    } instr_t;

    state_t      state_q, state_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;
    logic        illegal_q, illegal_d;

    instr_t      instr;
    logic [1:0]  exe_eop;
    logic [2:0]  exe_aluop;
    logic        exe_srcb;
    logic        retire;

    // Classify the instruction held in the IR.
    always_comb begin
        instr = I_ILLEGAL;
        unique case (op)
            6'b000000: begin
                unique case (funct)
                    6'b100001: instr = I_ADDU;
                    6'b100011: instr = I_SUBU;
                    6'b001000: instr = I_JR;
                    6'b000000: instr = I_NOP;
                    default:   instr = I_ILLEGAL;
                endcase
            end
            6'b001101: instr = I_ORI;
            6'b100011: instr = I_LW;
            6'b101011: instr = I_SW;
            6'b000100: instr = I_BEQ;
            6'b001111: instr = I_LUI;
            6'b000010: instr = I_J;
            6'b000011: instr = I_JAL;
            default:   instr = I_ILLEGAL;
        endcase
    end

    // Extender/ALU settings chosen in EXE and held through MEM and WB so the
    // ALU result stays stable while it is consumed.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first;
        // a path that leaves one unassigned would infer a latch.
        exe_eop   = 2'b00;
        exe_aluop = 3'b000;
        exe_srcb  = 1'b0;
        unique case (instr)
            I_SUBU: exe_aluop = 3'b001;
            I_ORI:  begin exe_aluop = 3'b010; exe_srcb = 1'b1; exe_eop = 2'b01; end
            I_LUI:  begin exe_aluop = 3'b011; exe_srcb = 1'b1; exe_eop = 2'b10; end
            I_LW,
            I_SW:   exe_srcb = 1'b1;
            I_BEQ:  begin exe_aluop = 3'b001; exe_eop = 2'b11; end
            default: ;
        endcase
    end

    // Next-state and control-output decode.
    always_comb begin
        state_d  = FETCH;
        PCWr     = 1'b0;
        IRWr     = 1'b0;
        RegWr    = 1'b0;
        MemWr    = 1'b0;
        EOp      = 2'b00;
        ALUOp    = 3'b000;
        ALUSrcB  = 1'b0;
        RegDst   = 2'b00;
        MemtoReg = 2'b00;
        NPCOp    = 2'b00;

        unique case (state_q)
            FETCH: begin
                IRWr    = 1'b1;
                PCWr    = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                unique case (instr)
                    I_J: begin
                        PCWr  = 1'b1;
                        NPCOp = 2'b10;
                    end
                    I_JAL: begin
                        // PC already holds PC+4, which is the link value.
                        PCWr     = 1'b1;
                        NPCOp    = 2'b10;
                        RegWr    = 1'b1;
                        RegDst   = 2'b10;
                        MemtoReg = 2'b10;
                    end
                    I_JR: begin
                        PCWr  = 1'b1;
                        NPCOp = 2'b11;
                    end
                    I_NOP, I_ILLEGAL: state_d = FETCH;
                    default:          state_d = EXE;
                endcase
            end
            EXE: begin
                EOp     = exe_eop;
                ALUOp   = exe_aluop;
                ALUSrcB = exe_srcb;
                unique case (instr)
                    I_BEQ: begin
                        NPCOp   = 2'b01;
                        PCWr    = zero;
                        state_d = FETCH;
                    end
                    I_LW, I_SW:                    state_d = MEM;
                    I_ADDU, I_SUBU, I_ORI, I_LUI:  state_d = WB;
                    default:                       state_d = FETCH;
                endcase
            end
            MEM: begin
                EOp     = exe_eop;
                ALUOp   = exe_aluop;
                ALUSrcB = exe_srcb;
                if (instr == I_SW) begin
                    MemWr   = 1'b1;
                    state_d = FETCH;
                end else if (instr == I_LW) begin
                    state_d = WB;
                end else begin
                    state_d = FETCH;
                end
            end
            WB: begin
                EOp      = exe_eop;
                ALUOp    = exe_aluop;
                ALUSrcB  = exe_srcb;
                RegWr    = 1'b1;
                RegDst   = (instr == I_ADDU || instr == I_SUBU) ? 2'b01 : 2'b00;
                MemtoReg = (instr == I_LW) ? 2'b01 : 2'b00;
                state_d  = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // Reset aborts the current instruction: nothing may be written and
        // the remaining controls sit at their FETCH defaults.
        if (reset) begin
            PCWr     = 1'b0;
            IRWr     = 1'b0;
            RegWr    = 1'b0;
            MemWr    = 1'b0;
            EOp      = 2'b00;
            ALUOp    = 3'b000;
            ALUSrcB  = 1'b0;
            RegDst   = 2'b00;
            MemtoReg = 2'b00;
            NPCOp    = 2'b00;
        end
    end

    // Retire count and sticky illegal flag.
    always_comb begin
        retire = (state_d == FETCH) &&
                 (state_q == DECODE || state_q == EXE ||
                  state_q == MEM    || state_q == WB) &&
                 !(state_q == DECODE && instr == I_ILLEGAL);
        instr_cnt_d = instr_cnt_q + 32'(retire);
        illegal_d   = illegal_q | (state_q == DECODE && instr == I_ILLEGAL);
    end

    // State, counter and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q     <= FETCH;
            instr_cnt_q <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_cnt_q <= instr_cnt_d;
            illegal_q   <= illegal_d;
        end
    end

    assign state     = state_q;
    assign instr_cnt = instr_cnt_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed cycle-by-cycle vectors for mc_ctrl. The driver sets
// inputs each cycle and queues the hand-computed expected outputs; a monitor
// pops and compares on the falling edge.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        PCWr, IRWr, RegWr, MemWr, ALUSrcB, illegal;
    logic [1:0]  EOp, RegDst, MemtoReg, NPCOp;
    logic [2:0]  ALUOp, state;
    logic [31:0] instr_cnt;

    typedef struct packed {
        logic [2:0]  st;
        logic [3:0]  strb;   // PCWr, IRWr, RegWr, MemWr
        logic [1:0]  eop;
        logic [2:0]  aluop;
        logic        srcb;
        logic [1:0]  rd;
        logic [1:0]  m2r;
        logic [1:0]  npc;
        logic [31:0] cnt;
        logic        ill;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  v;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   drv_done = 1'b0;

    mc_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .PCWr      (PCWr),
        .IRWr      (IRWr),
        .RegWr     (RegWr),
        .MemWr     (MemWr),
        .EOp       (EOp),
        .ALUOp     (ALUOp),
        .ALUSrcB   (ALUSrcB),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .NPCOp     (NPCOp),
        .state     (state),
        .instr_cnt (instr_cnt),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus: drive inputs, queue expected outputs, advance.
    task automatic cyc(input string tag, input logic rst, input logic [5:0] o,
                       input logic [5:0] f, input logic z, input logic [2:0] st,
                       input logic [3:0] strb, input logic [1:0] eop,
                       input logic [2:0] aluop, input logic srcb,
                       input logic [1:0] rd, input logic [1:0] m2r,
                       input logic [1:0] npc, input logic [31:0] cnt,
                       input logic ill);
        exp_t e;
        reset = rst;
        op    = o;
        funct = f;
        zero  = z;
        e.tag = tag;
        e.v   = '{st: st, strb: strb, eop: eop, aluop: aluop, srcb: srcb,
                  rd: rd, m2r: m2r, npc: npc, cnt: cnt, ill: ill};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the DUT against the oldest queued expectation.
    initial begin
        exp_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{st: state, strb: {PCWr, IRWr, RegWr, MemWr}, eop: EOp,
                      aluop: ALUOp, srcb: ALUSrcB, rd: RegDst, m2r: MemtoReg,
                      npc: NPCOp, cnt: instr_cnt, ill: illegal};
                checks++;
                if (a !== e.v) begin
                    errors++;
                    $display("FAIL %s: got st=%0d strb=%b eop=%b alu=%b srcb=%b rd=%b m2r=%b npc=%b cnt=%0d ill=%b, expected st=%0d strb=%b eop=%b alu=%b srcb=%b rd=%b m2r=%b npc=%b cnt=%0d ill=%b",
                             e.tag, a.st, a.strb, a.eop, a.aluop, a.srcb, a.rd, a.m2r, a.npc, a.cnt, a.ill,
                             e.v.st, e.v.strb, e.v.eop, e.v.aluop, e.v.srcb, e.v.rd, e.v.m2r, e.v.npc, e.v.cnt, e.v.ill);
                end
            end
        end
    end

    // Driver: directed instruction sequence.
    initial begin
        reset = 1'b1; op = '0; funct = '0; zero = 1'b0;
        @(posedge clk);
        #1;
        //   tag          rst op         funct      z  st   PIRM    eop    alu     sb    rd     m2r    npc    cnt ill
        cyc("rst0",       1, 6'b000000, 6'b000000, 0, 3'd0, 4'b0000, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        cyc("rst1",       1, 6'b000000, 6'b000000, 0, 3'd0, 4'b0000, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        // ori
        cyc("ori_fetch",  0, 6'b001101, 6'b000000, 0, 3'd0, 4'b1100, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        cyc("ori_dec",    0, 6'b001101, 6'b000000, 0, 3'd1, 4'b0000, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        cyc("ori_exe",    0, 6'b001101, 6'b000000, 0, 3'd2, 4'b0000, 2'b01, 3'b010, 1, 2'b00, 2'b00, 2'b00, 0, 0);
        cyc("ori_wb",     0, 6'b001101, 6'b000000, 0, 3'd4, 4'b0010, 2'b01, 3'b010, 1, 2'b00, 2'b00, 2'b00, 0, 0);
        // lw
        cyc("lw_fetch",   0, 6'b100011, 6'b000000, 0, 3'd0, 4'b1100, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 1, 0);
        cyc("lw_dec",     0, 6'b100011, 6'b000000, 0, 3'd1, 4'b0000, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 1, 0);
        cyc("lw_exe",     0, 6'b100011, 6'b000000, 0, 3'd2, 4'b0000, 2'b00, 3'b000, 1, 2'b00, 2'b00, 2'b00, 1, 0);
        cyc("lw_mem",     0, 6'b100011, 6'b000000, 0, 3'd3, 4'b0000, 2'b00, 3'b000, 1, 2'b00, 2'b00, 2'b00, 1, 0);
        cyc("lw_wb",      0, 6'b100011, 6'b000000, 0, 3'd4, 4'b0010, 2'b00, 3'b000, 1, 2'b00, 2'b01, 2'b00, 1, 0);
        // sw
        cyc("sw_fetch",   0, 6'b101011, 6'b000000, 0, 3'd0, 4'b1100, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 2, 0);
        cyc("sw_dec",     0, 6'b101011, 6'b000000, 0, 3'd1, 4'b0000, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 2, 0);
        cyc("sw_exe",     0, 6'b101011, 6'b000000, 0, 3'd2, 4'b0000, 2'b00, 3'b000, 1, 2'b00, 2'b00, 2'b00, 2, 0);
        cyc("sw_mem",     0, 6'b101011, 6'b000000, 0, 3'd3, 4'b0001, 2'b00, 3'b000, 1, 2'b00, 2'b00, 2'b00, 2, 0);
        // beq taken
        cyc("beq1_fetch", 0, 6'b000100, 6'b000000, 1, 3'd0, 4'b1100, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 3, 0);
        cyc("beq1_dec",   0, 6'b000100, 6'b000000, 1, 3'd1, 4'b0000, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 3, 0);
        cyc("beq1_exe",   0, 6'b000100, 6'b000000, 1, 3'd2, 4'b1000, 2'b11, 3'b001, 0, 2'b00, 2'b00, 2'b01, 3, 0);
        // beq not taken
        cyc("beq0_fetch", 0, 6'b000100, 6'b000000, 0, 3'd0, 4'b1100, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 4, 0);
        cyc("beq0_dec",   0, 6'b000100, 6'b000000, 0, 3'd1, 4'b0000, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 4, 0);
        cyc("beq0_exe",   0, 6'b000100, 6'b000000, 0, 3'd2, 4'b0000, 2'b11, 3'b001, 0, 2'b00, 2'b00, 2'b01, 4, 0);
        // jal, j, jr, nop
        cyc("jal_fetch",  0, 6'b000011, 6'b000000, 0, 3'd0, 4'b1100, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 5, 0);
        cyc("jal_dec",    0, 6'b000011, 6'b000000, 0, 3'd1, 4'b1010, 2'b00, 3'b000, 0, 2'b10, 2'b10, 2'b10, 5, 0);
        cyc("j_fetch",    0, 6'b000010, 6'b000000, 0, 3'd0, 4'b1100, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 6, 0);
        cyc("j_dec",      0, 6'b000010, 6'b000000, 0, 3'd1, 4'b1000, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b10, 6, 0);
        cyc("jr_fetch",   0, 6'b000000, 6'b001000, 0, 3'd0, 4'b1100, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 7, 0);
        cyc("jr_dec",     0, 6'b000000, 6'b001000, 0, 3'd1, 4'b1000, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b11, 7, 0);
        cyc("nop_fetch",  0, 6'b000000, 6'b000000, 0, 3'd0, 4'b1100, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 8, 0);
        cyc("nop_dec",    0, 6'b000000, 6'b000000, 0, 3'd1, 4'b0000, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 8, 0);
        // illegal op, then illegal funct: no count, flag sticks
        cyc("ill_fetch",  0, 6'b111111, 6'b000000, 0, 3'd0, 4'b1100, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 9, 0);
        cyc("ill_dec",    0, 6'b111111, 6'b000000, 0, 3'd1, 4'b0000, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 9, 0);
        cyc("illf_fetch", 0, 6'b000000, 6'b000001, 0, 3'd0, 4'b1100, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 9, 1);
        cyc("illf_dec",   0, 6'b000000, 6'b000001, 0, 3'd1, 4'b0000, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 9, 1);
        // addu, subu still complete
        cyc("addu_fetch", 0, 6'b000000, 6'b100001, 0, 3'd0, 4'b1100, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 9, 1);
        cyc("addu_dec",   0, 6'b000000, 6'b100001, 0, 3'd1, 4'b0000, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 9, 1);
        cyc("addu_exe",   0, 6'b000000, 6'b100001, 0, 3'd2, 4'b0000, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 9, 1);
        cyc("addu_wb",    0, 6'b000000, 6'b100001, 0, 3'd4, 4'b0010, 2'b00, 3'b000, 0, 2'b01, 2'b00, 2'b00, 9, 1);
        cyc("subu_fetch", 0, 6'b000000, 6'b100011, 0, 3'd0, 4'b1100, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 10, 1);
        cyc("subu_dec",   0, 6'b000000, 6'b100011, 0, 3'd1, 4'b0000, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 10, 1);
        cyc("subu_exe",   0, 6'b000000, 6'b100011, 0, 3'd2, 4'b0000, 2'b00, 3'b001, 0, 2'b00, 2'b00, 2'b00, 10, 1);
        cyc("subu_wb",    0, 6'b000000, 6'b100011, 0, 3'd4, 4'b0010, 2'b00, 3'b001, 0, 2'b01, 2'b00, 2'b00, 10, 1);
        // lui aborted by reset in WB
        cyc("lui_fetch",  0, 6'b001111, 6'b000000, 0, 3'd0, 4'b1100, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 11, 1);
        cyc("lui_dec",    0, 6'b001111, 6'b000000, 0, 3'd1, 4'b0000, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 11, 1);
        cyc("lui_exe",    0, 6'b001111, 6'b000000, 0, 3'd2, 4'b0000, 2'b10, 3'b011, 1, 2'b00, 2'b00, 2'b00, 11, 1);
        cyc("lui_wb_rst", 1, 6'b001111, 6'b000000, 0, 3'd4, 4'b0000, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 11, 1);
        cyc("post_rst",   0, 6'b001101, 6'b000000, 0, 3'd0, 4'b1100, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        cyc("post_dec",   0, 6'b001101, 6'b000000, 0, 3'd1, 4'b0000, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        drv_done = 1'b1;
    end

    // Wait for the driver and the monitor to drain, bounded, then summarise.
    initial begin
        int budget;
        budget = 0;
        while (!(drv_done && exp_q.size() == 0) && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        if (budget >= 2000) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
